// File: rtl/mul_pipeline.sv
// Five-stage RV32M MUL unit (EX1..EX5), one 8-bit rs2 slice accumulated per stage.
// Optional performance counters are enabled with `define MUL_PERF_CNT_EN.

package params_pkg;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REGISTER_WIDTH = 5;
endpackage

module mul_pipeline #(
    parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int unsigned SLICE_WIDTH    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    input  logic                      hold_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    output logic                      ex1_valid_o,
    output logic                      ex2_valid_o,
    output logic                      ex3_valid_o,
    output logic                      ex4_valid_o,
    output logic                      ex5_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex5_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     ex5_result_o,
    output logic                      wb_valid_o
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]               mul_retired_cnt_o,
    output logic [31:0]               mul_hold_cnt_o
`endif
);

    // Accumulating stages EX1..EX4; DATA_WIDTH/SLICE_WIDTH is expected to be 4.
    localparam int unsigned NUM_ACC = DATA_WIDTH / SLICE_WIDTH;

    logic                      valid_q  [NUM_ACC];
    logic [REGISTER_WIDTH-1:0] wr_reg_q [NUM_ACC];
    logic [DATA_WIDTH-1:0]     acc_q    [NUM_ACC];
    // Operands are only needed by stages that still have a slice to add.
    logic [DATA_WIDTH-1:0]     rs1_q    [NUM_ACC-1];
    logic [DATA_WIDTH-1:0]     rs2_q    [NUM_ACC-1];

    logic                      ex5_valid_q;
    logic [REGISTER_WIDTH-1:0] ex5_wr_reg_q;
    logic [DATA_WIDTH-1:0]     ex5_result_q;

    // (a << idx*SLICE) * rs2 slice idx, truncated to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] partial_product(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input int unsigned           idx
    );
        logic [SLICE_WIDTH-1:0] slice;
        slice = SLICE_WIDTH'(b >> (idx * SLICE_WIDTH));
        return DATA_WIDTH'((a << (idx * SLICE_WIDTH)) * DATA_WIDTH'(slice));
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_ACC; k++) begin
                valid_q[k]  <= 1'b0;
                wr_reg_q[k] <= '0;
                acc_q[k]    <= '0;
            end
            for (int unsigned k = 0; k < NUM_ACC - 1; k++) begin
                rs1_q[k] <= '0;
                rs2_q[k] <= '0;
            end
            ex5_valid_q  <= 1'b0;
            ex5_wr_reg_q <= '0;
            ex5_result_q <= '0;
        end else if (!hold_i) begin
            valid_q[0]  <= valid_i;
            wr_reg_q[0] <= wr_reg_i;
            rs1_q[0]    <= rs1_data_i;
            rs2_q[0]    <= rs2_data_i;
            acc_q[0]    <= partial_product(rs1_data_i, rs2_data_i, 0);
            for (int unsigned k = 1; k < NUM_ACC; k++) begin
                valid_q[k]  <= valid_q[k-1];
                wr_reg_q[k] <= wr_reg_q[k-1];
                acc_q[k]    <= acc_q[k-1] + partial_product(rs1_q[k-1], rs2_q[k-1], k);
            end
            for (int unsigned k = 1; k < NUM_ACC - 1; k++) begin
                rs1_q[k] <= rs1_q[k-1];
                rs2_q[k] <= rs2_q[k-1];
            end
            ex5_valid_q  <= valid_q[NUM_ACC-1];
            ex5_wr_reg_q <= wr_reg_q[NUM_ACC-1];
            // x0 writes must bypass as zero.
            ex5_result_q <= (wr_reg_q[NUM_ACC-1] == '0) ? '0 : acc_q[NUM_ACC-1];
        end
    end

    assign ex1_valid_o  = valid_q[0];
    assign ex2_valid_o  = valid_q[1];
    assign ex3_valid_o  = valid_q[2];
    assign ex4_valid_o  = valid_q[3];
    assign ex5_valid_o  = ex5_valid_q;
    assign ex1_wr_reg_o = wr_reg_q[0];
    assign ex2_wr_reg_o = wr_reg_q[1];
    assign ex3_wr_reg_o = wr_reg_q[2];
    assign ex4_wr_reg_o = wr_reg_q[3];
    assign ex5_wr_reg_o = ex5_wr_reg_q;
    assign ex5_result_o = ex5_result_q;
    assign wb_valid_o   = ex5_valid_q & ~hold_i;

`ifdef MUL_PERF_CNT_EN
    logic        any_valid;
    logic [31:0] retired_cnt_q;
    logic [31:0] hold_cnt_q;

    assign any_valid = valid_q[0] | valid_q[1] | valid_q[2] | valid_q[3] | ex5_valid_q;

    // Free-running counters, wrapping naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_cnt_q <= '0;
            hold_cnt_q    <= '0;
        end else begin
            if (wb_valid_o) begin
                retired_cnt_q <= retired_cnt_q + 32'd1;
            end
            if (hold_i && any_valid) begin
                hold_cnt_q <= hold_cnt_q + 32'd1;
            end
        end
    end

    assign mul_retired_cnt_o = retired_cnt_q;
    assign mul_hold_cnt_o    = hold_cnt_q;
`endif

endmodule

// File: tb/tb_mul_pipeline.sv
// Self-checking bench for mul_pipeline: slot-level model of the 5-deep pipe
// whose EX5 result is the plain product a*b (zero for an x0 destination).

module tb_mul_pipeline;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid;
    logic        hold;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;

    logic        v1, v2, v3, v4, v5;
    logic [4:0]  t1, t2, t3, t4, t5;
    logic [31:0] result;
    logic        wb_valid;
`ifdef MUL_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] hold_cnt;
`endif

    mul_pipeline dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .valid_i      (valid),
        .hold_i       (hold),
        .rs1_data_i   (rs1),
        .rs2_data_i   (rs2),
        .wr_reg_i     (rd),
        .ex1_valid_o  (v1),
        .ex2_valid_o  (v2),
        .ex3_valid_o  (v3),
        .ex4_valid_o  (v4),
        .ex5_valid_o  (v5),
        .ex1_wr_reg_o (t1),
        .ex2_wr_reg_o (t2),
        .ex3_wr_reg_o (t3),
        .ex4_wr_reg_o (t4),
        .ex5_wr_reg_o (t5),
        .ex5_result_o (result),
        .wb_valid_o   (wb_valid)
`ifdef MUL_PERF_CNT_EN
        ,
        .mul_retired_cnt_o (retired_cnt),
        .mul_hold_cnt_o    (hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: slot i holds the instruction currently in EX(i+1).
    logic        mv  [5];
    logic [4:0]  mrd [5];
    logic [31:0] ma  [5];
    logic [31:0] mb  [5];
    int          exp_retired = 0;
    int          exp_held    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            mv[i] = 1'b0; mrd[i] = '0; ma[i] = '0; mb[i] = '0;
        end
    endtask

    function automatic logic [31:0] model_product(input int i);
        logic [63:0] p;
        p = 64'(ma[i]) * 64'(mb[i]);
        return (mrd[i] == 5'd0) ? 32'd0 : p[31:0];
    endfunction

    // Compare every visible output against the model for the current cycle.
    task automatic check_all();
        logic       dv [5];
        logic [4:0] dt [5];
        dv[0] = v1; dv[1] = v2; dv[2] = v3; dv[3] = v4; dv[4] = v5;
        dt[0] = t1; dt[1] = t2; dt[2] = t3; dt[3] = t4; dt[4] = t5;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ex%0d_valid", i + 1), 32'(dv[i]), 32'(mv[i]));
            if (mv[i]) chk($sformatf("ex%0d_wr_reg", i + 1), 32'(dt[i]), 32'(mrd[i]));
        end
        if (mv[4]) chk("ex5_result", result, model_product(4));
        chk("wb_valid", 32'(wb_valid), 32'(mv[4] & ~hold));
    endtask

    task automatic model_advance();
        if (hold) begin
            if (mv[0] | mv[1] | mv[2] | mv[3] | mv[4]) exp_held++;
        end else begin
            if (mv[4]) exp_retired++;
            for (int i = 4; i > 0; i--) begin
                mv[i] = mv[i-1]; mrd[i] = mrd[i-1]; ma[i] = ma[i-1]; mb[i] = mb[i-1];
            end
            mv[0] = valid; mrd[0] = rd; ma[0] = rs1; mb[0] = rs2;
        end
    endtask

    // One clock: drive inputs in the low phase, check, take the edge, return at negedge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic h);
        valid = v; rs1 = a; rs2 = b; rd = r; hold = h;
        #1;
        check_all();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd31, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0; valid = 1'b0; hold = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        model_clear();
        #2;
        chk("reset_ex1_valid", 32'(v1), 32'd0);
        chk("reset_ex5_valid", 32'(v5), 32'd0);
        chk("reset_ex3_wr_reg", 32'(t3), 32'd0);
        chk("reset_ex5_wr_reg", 32'(t5), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Single issue: 7*6 -> 42 after five edges.
        cycle(1'b1, 32'd7, 32'd6, 5'd5, 1'b0);
        chk("single_ex1_tag", 32'(t1), 32'd5);
        idle(4);
        chk("single_ex5_valid", 32'(v5), 32'd1);
        chk("single_result", result, 32'd42);
        idle(2);

        // Back-to-back issues retire on consecutive cycles.
        cycle(1'b1, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
        cycle(1'b1, 32'h1234_5678, 32'h10, 5'd4, 1'b0);
        cycle(1'b1, 32'h8000_0000, 32'd2, 5'd6, 1'b0);
        idle(2);
        chk("b2b_result0", result, 32'hFFFF_FFFE);
        idle(1);
        chk("b2b_result1", result, 32'h2345_6780);
        idle(1);
        chk("b2b_result2", result, 32'h0000_0000);
        chk("b2b_tag2", 32'(t5), 32'd6);
        idle(2);

        // Hold two cycles while the op sits in EX3; issue attempts under hold are lost.
        cycle(1'b1, 32'd3, 32'd5, 5'd9, 1'b0);
        idle(2);
        cycle(1'b1, 32'd11, 32'd11, 5'd12, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
        chk("hold_ex3_valid", 32'(v3), 32'd1);
        chk("hold_ex3_tag", 32'(t3), 32'd9);
        chk("hold_ex1_valid", 32'(v1), 32'd0);
        idle(2);
        chk("hold_result", result, 32'd15);
        idle(3);

        // x0 destination occupies the pipe but bypasses zero.
        cycle(1'b1, 32'd100, 32'd100, 5'd0, 1'b0);
        idle(4);
        chk("x0_valid", 32'(v5), 32'd1);
        chk("x0_tag", 32'(t5), 32'd0);
        chk("x0_result", result, 32'd0);
        idle(2);

        // Mixed stream with bubbles, holds and slice-boundary operands.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = 32'h0101_0101 * 32'(i + 1) + 32'h00FF_00FF;
            b = (32'hFF << (8 * (i % 4))) | 32'(i);
            cycle((i % 5) != 3, a, b, 5'(i + 1), (i == 6) || (i == 7) || (i == 12));
        end
        idle(6);

        // Asynchronous reset with ops in EX2 and EX4; nothing may retire after.
        cycle(1'b1, 32'd9, 32'd9, 5'd20, 1'b0);
        idle(1);
        cycle(1'b1, 32'd8, 32'd8, 5'd21, 1'b0);
        idle(1);
        chk("pre_rst_ex4_valid", 32'(v4), 32'd1);
        chk("pre_rst_ex2_valid", 32'(v2), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_ex2_valid", 32'(v2), 32'd0);
        chk("rst_ex4_valid", 32'(v4), 32'd0);
        chk("rst_result", result, 32'd0);
        model_clear();
        #1;
        rst_ni = 1'b1;
        idle(7);

`ifdef MUL_PERF_CNT_EN
        chk("perf_retired", retired_cnt, 32'(exp_retired));
        chk("perf_held", hold_cnt, 32'(exp_held));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
